// File: rtl/dc_offset_inject.sv
// dc_offset_inject
//   Adds a programmable signed DC offset to a sample stream ahead of the DAC.
//   Offset changes are slew-limited: the applied offset walks toward the
//   loaded target by 1 LSB every 2^STEPN clocks. The output is saturated
//   symmetrically to +/-(2^(WIDTH-1)-1), and saturated samples are counted.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   we, data_in    input sample strobe and signed sample
//   offset_target  signed requested offset, latched on offset_load
//   offset_load    one-cycle pulse: take offset_target as the new target
//   sat_clr        clear sat_cnt (wins over a same-cycle increment)
//   data_out/valid offset-injected, saturated sample and its strobe (1 clk latency)
//   offset_cur     signed offset currently applied
//   ramping        high while offset_cur has not yet reached the target
//   sat_cnt        saturated-sample count, sticky at all-ones
module dc_offset_inject #(
    parameter int WIDTH = 14,
    parameter int STEPN = 4,
    parameter int SATW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] offset_target,
    input  logic             offset_load,
    input  logic             sat_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic [WIDTH-1:0] offset_cur,
    output logic             ramping,
    output logic [SATW-1:0]  sat_cnt
);

    localparam logic signed [WIDTH:0] MAX_S    = (WIDTH+1)'((2**(WIDTH-1)) - 1);
    localparam logic signed [WIDTH:0] MIN_S    = -MAX_S;
    localparam logic [WIDTH-1:0]      MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]      MIN_W    = MOST_NEG + WIDTH'(1);
    localparam logic [STEPN-1:0]      STEP_END = '1;

    typedef enum logic {HOLD, RAMP} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  target, target_n, offset_n, tgt_clamped;
    logic [STEPN-1:0]  step_cnt, step_n;
    logic signed [WIDTH:0] sum;
    logic              sat_hi, sat_lo;

    // Only the most negative code lies outside the symmetric range.
    assign tgt_clamped = (offset_target == MOST_NEG) ? MIN_W : offset_target;

    // One extra bit of headroom so the sum cannot wrap before clamping.
    assign sum    = {data_in[WIDTH-1], data_in} + {offset_cur[WIDTH-1], offset_cur};
    assign sat_hi = (sum > MAX_S);
    assign sat_lo = (sum < MIN_S);

    assign ramping = (state == RAMP);

    // Next-state / offset stepping. A load wins over a step on the same
    // edge: it retargets and restarts the step timing from zero.
    always_comb begin
        state_n  = state;
        target_n = target;
        step_n   = step_cnt;
        offset_n = offset_cur;
        if (offset_load) begin
            target_n = tgt_clamped;
            step_n   = '0;
            state_n  = (tgt_clamped != offset_cur) ? RAMP : HOLD;
        end else if (state == RAMP) begin
            if (step_cnt == STEP_END) begin
                step_n   = '0;
                offset_n = ($signed(target) > $signed(offset_cur)) ?
                           offset_cur + WIDTH'(1) : offset_cur - WIDTH'(1);
                if (offset_n == target)
                    state_n = HOLD;
            end else begin
                step_n = step_cnt + STEPN'(1);
            end
        end else begin
            step_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HOLD;
            target     <= '0;
            step_cnt   <= '0;
            offset_cur <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            sat_cnt    <= '0;
        end else begin
            state      <= state_n;
            target     <= target_n;
            step_cnt   <= step_n;
            offset_cur <= offset_n;
            valid      <= we;
            if (we) begin
                if (sat_hi)
                    data_out <= MAX_S[WIDTH-1:0];
                else if (sat_lo)
                    data_out <= MIN_S[WIDTH-1:0];
                else
                    data_out <= sum[WIDTH-1:0];
            end
            if (sat_clr)
                sat_cnt <= '0;
            else if (we && (sat_hi || sat_lo) && (sat_cnt != '1))
                sat_cnt <= sat_cnt + SATW'(1);
        end
    end

endmodule

// File: doc/dc_offset_inject.md
Name: dc_offset_inject

Overview:
- TX/DAC-side counterpart of the ADC-side mean-removal compensator: adds a programmable signed DC offset to a sample stream instead of removing one.
- Offset changes are slew-limited: the applied offset ramps toward a loaded target by 1 LSB every 2^STEPN clocks, so the output never steps abruptly.
- Output is saturated symmetrically to ±(2^(WIDTH-1)-1), and saturation events are counted.
- Sits between the baseband sample source and the DAC interface; also used to inject a known DC for compensator calibration.

Parameters:
WIDTH, 14, sample and offset width (signed two's complement)
STEPN, 4, log2 of clocks per 1-LSB offset step during a ramp
SATW, 16, width of the saturation event counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
we  in  1  input sample strobe
data_in  in  WIDTH  signed input sample
offset_target  in  WIDTH  signed requested offset
offset_load  in  1  one-cycle pulse: latch offset_target as the new target
sat_clr  in  1  clear sat_cnt
data_out  out  WIDTH  signed offset-injected, saturated sample
valid  out  1  data_out strobe
offset_cur  out  WIDTH  signed offset currently applied
ramping  out  1  high while offset_cur != target
sat_cnt  out  SATW  count of saturated samples, sticky at all-ones

Behaviour:
- Reset is synchronous, active-high, on clk. While rst=1, next edge sets:
  - data_out=0, valid=0, offset_cur=0, sat_cnt=0
  - internal target=0, step counter=0, state=HOLD
  - ramping=0
- Reset mid-ramp abandons the ramp: offset returns to 0 immediately and no ramp toward 0 occurs.
- MAX_LIM = 2^(WIDTH-1)-1. Only ±MAX_LIM is representable at the output; -2^(WIDTH-1) is never produced.
- Target latch:
  - On offset_load=1, target <= offset_target clamped to [-MAX_LIM, MAX_LIM]; step counter <= 0.
  - Next state is RAMP if the clamped value != offset_cur, else HOLD.
  - offset_load during RAMP retargets and restarts step timing; the direction is recomputed from the new target.
- State machine, 2 states:
  - HOLD: offset_cur constant; step counter held at 0; ramping=0.
  - RAMP: step counter increments each clk. When it equals 2^STEPN-1:
    - offset_cur moves 1 LSB toward target;
    - step counter wraps to 0;
    - if the new offset_cur equals target, state goes to HOLD.
  - ramping is registered and equals (state==RAMP). It deasserts on the same edge that offset_cur reaches target.
  - With offset_load low, a ramp of N LSB takes exactly N·2^STEPN clocks from the load edge.
- Datapath, 1-cycle latency:
  - sum = data_in + offset_cur, computed in WIDTH+1 bits signed.
  - If we=1: data_out <= clamp(sum, -MAX_LIM, +MAX_LIM). If we=0: data_out holds.
  - offset_cur used is the registered value before any step occurring on the same edge.
  - valid <= we every clk (cleared by rst).
- Saturation counting:
  - sat_cnt increments when we=1 and sum > MAX_LIM or sum < -MAX_LIM.
  - sat_cnt is sticky at 2^SATW-1 and never wraps.
  - sat_clr=1 sets sat_cnt to 0 and takes priority over a simultaneous increment.
- offset_load and we are independent; a load on the same cycle as a sample does not affect that sample.

Test Plan:
1. WIDTH=14, STEPN=2. Reset, then we=1 with data_in=100 and offset 0 -> data_out=100 and valid=1 one clk later; ramping=0; sat_cnt=0.
2. Load target 3 -> offset_cur becomes 1, 2, 3 at 4, 8, 12 clks after the load edge; ramping=1 for exactly 12 clks. Sample 100 during the 2nd step window -> data_out=101.
3. Offset settled at 10, data_in=8190 -> data_out=8191 and sat_cnt=1. Offset settled at -5, data_in=-8192 -> data_out=-8191 and sat_cnt=2. Assert sat_clr with a saturating sample on the same cycle -> sat_cnt=0.
4. Load target 5; when offset_cur=2, load -1 -> next change is 2->1 exactly 4 clks later, then 0 and -1; ramping drops when offset_cur reaches -1.
5. Load target equal to offset_cur -> ramping stays 0. Load -8192 -> target clamped to -8191 and the ramp ends at -8191, never at -8192.
6. Assert rst mid-ramp at offset_cur=7 while valid=1 -> next clk all outputs are 0. After release, a sample of 50 gives data_out=50 with no residual ramp.
